// File: rtl/stp_frame_ctrl.sv
// stp_frame_ctrl: loads samples into a serial-to-parallel register and holds the frame until the FFT core consumes it.
module stp_frame_ctrl #(
   parameter int N_SAMPLES = 48,
   parameter int DATA_W    = 16
) (
   input  logic              clk,
   input  logic              n_rst,
   input  logic              en,
   input  logic              sample_valid,
   input  logic [DATA_W-1:0] sample_in,
   output logic              sample_ready,
   output logic              shift_en,
   output logic [DATA_W-1:0] shift_data,
   output logic              frame_valid,
   input  logic              frame_ready,
   output logic              overrun,
   input  logic              ovr_clr,
   output logic [7:0]        frame_cnt
);
   localparam int CW = N_SAMPLES > 1 ? $clog2(N_SAMPLES) : 1;
   localparam logic [CW-1:0] LAST = CW'(N_SAMPLES - 1);
   typedef enum logic [1:0] {IDLE, LOAD, HOLD} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] count_q, count_d;
   logic shift_en_q, frame_valid_q, frame_valid_d, overrun_q, overrun_d;
   logic [DATA_W-1:0] shift_data_q, shift_data_d;
   logic [7:0] frame_cnt_q, frame_cnt_d;
   logic accept, consume;
   assign sample_ready = (state_q == LOAD) && en;
   assign accept       = sample_valid && sample_ready;
   assign consume      = frame_valid_q && frame_ready;
   assign shift_en     = shift_en_q;
   assign shift_data   = shift_data_q;
   assign frame_valid  = frame_valid_q;
   assign overrun      = overrun_q;
   assign frame_cnt    = frame_cnt_q;
   always_comb begin
      state_d       = state_q;
      count_d       = count_q;
      shift_data_d  = accept ? sample_in : shift_data_q;
      // the only shift pulse seen in HOLD is the final sample, so the frame becomes valid as it is captured
      frame_valid_d = (state_q == HOLD && shift_en_q) || (frame_valid_q && !frame_ready);
      overrun_d     = (sample_valid && frame_valid_q) || (overrun_q && !ovr_clr);
      frame_cnt_d   = frame_cnt_q + 8'(consume);
      case (state_q)
         IDLE: state_d = en ? LOAD : IDLE;
         LOAD: begin
            if (!en) begin
               state_d = IDLE;
               count_d = '0;
            end else if (accept) begin
               state_d = (count_q == LAST) ? HOLD : LOAD;
               count_d = (count_q == LAST) ? '0 : count_q + 1'b1;
            end
         end
         HOLD: state_d = consume ? (en ? LOAD : IDLE) : HOLD;
         default: state_d = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q       <= IDLE;
         count_q       <= '0;
         shift_en_q    <= 1'b0;
         shift_data_q  <= '0;
         frame_valid_q <= 1'b0;
         overrun_q     <= 1'b0;
         frame_cnt_q   <= '0;
      end else begin
         state_q       <= state_d;
         count_q       <= count_d;
         shift_en_q    <= accept;
         shift_data_q  <= shift_data_d;
         frame_valid_q <= frame_valid_d;
         overrun_q     <= overrun_d;
         frame_cnt_q   <= frame_cnt_d;
      end
   end
endmodule

// File: tb/tb_stp_frame_ctrl.sv
// tb_stp_frame_ctrl: vector table, directed frame sequences and random traffic against a behavioural model.
module tb_stp_frame_ctrl;
   localparam int N = 48;
   logic clk, n_rst, en, sample_valid, frame_ready, ovr_clr;
   logic [15:0] sample_in;
   logic sample_ready, shift_en, frame_valid, overrun;
   logic [15:0] shift_data;
   logic [7:0] frame_cnt;
   int n_chk, n_fail;
   logic [15:0] sipo[$];
   int tick_no, first_pulse, last_pulse;
   bit m_loading, m_holding, m_gap, m_fv, m_ovr, m_sh;
   int m_got, m_cnt;
   logic [15:0] m_dat;

   stp_frame_ctrl #(.N_SAMPLES(N), .DATA_W(16)) dut (
      .clk(clk), .n_rst(n_rst), .en(en), .sample_valid(sample_valid), .sample_in(sample_in),
      .sample_ready(sample_ready), .shift_en(shift_en), .shift_data(shift_data),
      .frame_valid(frame_valid), .frame_ready(frame_ready), .overrun(overrun),
      .ovr_clr(ovr_clr), .frame_cnt(frame_cnt));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1);
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at t=%0t: got %0h required %0h", name, $time, act, exp);
      end
   endtask

   task automatic model_reset();
      m_loading = 0; m_holding = 0; m_gap = 0; m_fv = 0; m_ovr = 0; m_sh = 0;
      m_got = 0; m_cnt = 0; m_dat = '0;
   endtask

   // One clock edge of the frame protocol, stated in terms of samples collected and frames pending
   task automatic model_step();
      bit acc, cons;
      acc = m_loading && en && sample_valid;
      cons = m_fv && frame_ready;
      m_ovr = (sample_valid && m_fv) || (m_ovr && !ovr_clr);
      m_sh = acc;
      if (acc) m_dat = sample_in;
      if (m_gap) begin m_fv = 1; m_gap = 0; end
      if (m_loading) begin
         if (!en) begin m_loading = 0; m_got = 0; end
         else if (acc) begin
            m_got++;
            if (m_got == N) begin m_got = 0; m_loading = 0; m_holding = 1; m_gap = 1; end
         end
      end else if (!m_holding) m_loading = en;
      else if (cons) begin
         m_fv = 0; m_cnt = (m_cnt + 1) % 256; m_holding = 0; m_loading = en;
      end
   endtask

   task automatic compare_model();
      chk("sample_ready", sample_ready, m_loading && en);
      chk("shift_en", shift_en, m_sh);
      chk("shift_data", shift_data, m_dat);
      chk("frame_valid", frame_valid, m_fv);
      chk("overrun", overrun, m_ovr);
      chk("frame_cnt", frame_cnt, m_cnt);
   endtask

   task automatic tick();
      if (n_rst) model_step();
      @(posedge clk);
      #1;
      tick_no++;
      if (shift_en) begin
         sipo.push_back(shift_data);
         if (first_pulse < 0) first_pulse = tick_no;
         last_pulse = tick_no;
      end
      compare_model();
   endtask

   task automatic drive(input bit e, input bit v, input logic [15:0] d, input bit fr, input bit oc);
      en = e; sample_valid = v; sample_in = d; frame_ready = fr; ovr_clr = oc;
   endtask

   task automatic do_reset();
      @(negedge clk);
      #2;
      n_rst = 0;
      #1;
      model_reset();
      chk("rst sample_ready", sample_ready, 0);
      chk("rst shift_en", shift_en, 0);
      chk("rst shift_data", shift_data, 0);
      chk("rst frame_valid", frame_valid, 0);
      chk("rst overrun", overrun, 0);
      chk("rst frame_cnt", frame_cnt, 0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst held frame_cnt", frame_cnt, 0);
      @(negedge clk);
      n_rst = 1;
   endtask

   // Loads one full frame with values base..base+N-1 and stops with the frame held
   task automatic run_frame(input int base, input bit gap);
      int k, c;
      sipo.delete();
      first_pulse = -1; last_pulse = -1;
      drive(1, 0, 0, 0, 0);
      tick();
      k = 0; c = 0;
      while (sipo.size() < N && c < 200) begin
         sample_valid = gap ? (c % 2 == 0) : 1'b1;
         sample_in = 16'(base + k);
         if (sample_valid) k++;
         tick();
         c++;
      end
      chk("frame pulse count", sipo.size(), N);
      chk("frame_valid before capture", frame_valid, 0);
      sample_valid = 0;
      tick();
      chk("frame_valid after last pulse", frame_valid, 1);
      for (int i = 0; i < sipo.size(); i++) chk("sipo contents", sipo[i], 32'(base + i));
   endtask

   typedef struct {
      bit en, sv;
      logic [15:0] din;
      bit e_rdy, e_sh;
      logic [15:0] e_dat;
      bit e_fv;
   } vec_t;
   vec_t tbl[10];

   initial begin
      int p;
      n_chk = 0; n_fail = 0; tick_no = 0; first_pulse = -1; last_pulse = -1;
      tbl = '{
         '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b0},
         '{1'b1, 1'b1, 16'h00AA, 1'b1, 1'b0, 16'h0000, 1'b0},
         '{1'b1, 1'b1, 16'h0001, 1'b1, 1'b1, 16'h0001, 1'b0},
         '{1'b1, 1'b0, 16'h0055, 1'b1, 1'b0, 16'h0001, 1'b0},
         '{1'b1, 1'b1, 16'h0002, 1'b1, 1'b1, 16'h0002, 1'b0},
         '{1'b0, 1'b1, 16'h0003, 1'b0, 1'b0, 16'h0002, 1'b0},
         '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0002, 1'b0},
         '{1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 16'h0002, 1'b0},
         '{1'b1, 1'b1, 16'h0010, 1'b1, 1'b1, 16'h0010, 1'b0},
         '{1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'h0010, 1'b0}
      };
      n_rst = 0;
      drive(0, 0, 0, 0, 0);
      model_reset();
      do_reset();
      foreach (tbl[i]) begin
         drive(tbl[i].en, tbl[i].sv, tbl[i].din, 0, 0);
         tick();
         chk("vec ready", sample_ready, tbl[i].e_rdy);
         chk("vec shift_en", shift_en, tbl[i].e_sh);
         chk("vec shift_data", shift_data, tbl[i].e_dat);
         chk("vec frame_valid", frame_valid, tbl[i].e_fv);
      end
      run_frame(0, 0);
      chk("full frame span", last_pulse - first_pulse + 1, N);
      drive(1, 0, 0, 1, 0);
      tick();
      chk("consume frame_valid", frame_valid, 0);
      chk("consume frame_cnt", frame_cnt, 1);
      drive(1, 1, 16'h0100, 0, 0);
      tick();
      chk("accept after consume", shift_en, 1);
      drive(0, 0, 0, 0, 0);
      tick();
      run_frame(16'h0200, 0);
      p = 0;
      for (int i = 0; i < 20; i++) begin
         drive(1, 1, 16'(i), 0, 0);
         tick();
         if (shift_en) p++;
      end
      chk("backpressure pulses", p, 0);
      chk("backpressure overrun", overrun, 1);
      chk("backpressure frame_valid", frame_valid, 1);
      drive(1, 1, 0, 0, 1);
      tick();
      chk("overrun set wins", overrun, 1);
      drive(1, 0, 0, 0, 1);
      tick();
      chk("overrun cleared", overrun, 0);
      drive(0, 0, 0, 1, 0);
      tick();
      chk("consume to idle cnt", frame_cnt, 2);
      tick();
      chk("idle ready", sample_ready, 0);
      drive(1, 0, 0, 0, 0);
      tick();
      for (int i = 0; i < 10; i++) begin
         drive(1, 1, 16'(16'h0300 + i), 0, 0);
         tick();
      end
      drive(0, 0, 0, 0, 0);
      tick();
      tick();
      chk("abort ready", sample_ready, 0);
      chk("abort frame_valid", frame_valid, 0);
      run_frame(16'h0400, 0);
      drive(0, 0, 0, 1, 0);
      tick();
      chk("abort then frame cnt", frame_cnt, 3);
      drive(1, 0, 0, 0, 0);
      tick();
      for (int i = 0; i < 30; i++) begin
         drive(1, 1, 16'(16'h0500 + i), 0, 0);
         tick();
      end
      do_reset();
      run_frame(16'h0600, 0);
      drive(0, 0, 0, 1, 0);
      tick();
      chk("post reset frame_cnt", frame_cnt, 1);
      run_frame(16'h0700, 1);
      chk("gapped span", last_pulse - first_pulse + 1, 95);
      p = 0;
      for (int i = 0; i < 5; i++) begin
         drive(1, 0, 0, 0, 0);
         tick();
         if (frame_valid) p++;
      end
      chk("gapped single frame held", p, 5);
      drive(1, 0, 0, 1, 0);
      tick();
      chk("gapped consume", frame_valid, 0);
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(0, 799) == 0) do_reset();
         drive($urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0, 16'($urandom),
               $urandom_range(0, 3) == 0, $urandom_range(0, 7) == 0);
         tick();
         sipo.delete();
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule

// File: doc/stp_frame_ctrl.md
STP_FRAME_CTRL -- requirements
Module: stp_frame_ctrl

Parameters
REQ-001 SHALL have parameter N_SAMPLES, default 48: samples per FFT frame held by the serial-to-parallel register.
REQ-002 SHALL have parameter DATA_W, default 16: sample width in bits.

Interface
REQ-003 SHALL have port clk, input, 1: single system clock; all state updates on its rising edge.
REQ-004 SHALL have port n_rst, input, 1: reset, asynchronous and active-low.
REQ-005 SHALL have port en, input, 1: load enable (level).
REQ-006 SHALL have port sample_valid, input, 1: upstream sample present.
REQ-007 SHALL have port sample_in, input, DATA_W: upstream sample.
REQ-008 SHALL have port sample_ready, output, 1: controller accepts sample this cycle.
REQ-009 SHALL have port shift_en, output, 1: strobe to the serial-to-parallel register (its it_cnt_strobe input).
REQ-010 SHALL have port shift_data, output, DATA_W: sample to the serial-to-parallel register (its serial_in input).
REQ-011 SHALL have port frame_valid, output, 1: complete frame held in the register.
REQ-012 SHALL have port frame_ready, input, 1: FFT core consumes the frame.
REQ-013 SHALL have port overrun, output, 1: sticky flag; sample offered while the frame is held.
REQ-014 SHALL have port ovr_clr, input, 1: synchronous clear of overrun.
REQ-015 SHALL have port frame_cnt, output, 8: count of consumed frames; wraps modulo 256.

Function
REQ-016 SHALL implement FSM states IDLE, LOAD and HOLD, plus a sample counter of width clog2(N_SAMPLES).
REQ-017 In IDLE: sample_ready=0 and count=0; en=1 moves the FSM to LOAD on the next edge.
REQ-018 In LOAD: sample_ready = en.
REQ-019 An accept occurs at an edge where sample_valid and sample_ready are both high.
REQ-020 On each accept, the controller SHALL register shift_en=1 and shift_data=sample_in for exactly the following cycle; otherwise shift_en=0 and shift_data holds its last value.
REQ-021 Each accept SHALL increment count; the accept at count=N_SAMPLES-1 SHALL clear count and enter HOLD.
REQ-022 frame_valid SHALL rise one cycle after the final shift_en pulse, i.e. on the edge at which the register captures sample N_SAMPLES-1, and then stay high until consumed.
REQ-023 In HOLD: sample_ready=0 and shift_en=0.
REQ-024 An edge with frame_valid and frame_ready both high consumes the frame: frame_valid clears, frame_cnt increments, and the FSM goes to LOAD if en=1, else to IDLE.
REQ-025 frame_ready while frame_valid=0 (including the one-cycle gap after entering HOLD) SHALL be ignored.
REQ-026 en=0 in LOAD SHALL return the FSM to IDLE and clear count; the partial frame is discarded and no frame_valid is produced. A shift_en pulse already registered still issues.
REQ-027 en SHALL be ignored in HOLD, apart from the exit decision in REQ-024.
REQ-028 sample_valid=1 with frame_valid=1 SHALL set overrun; the sample is dropped.
REQ-029 ovr_clr SHALL clear overrun; if ovr_clr and a set condition occur on the same edge, the set wins.
REQ-030 Back-to-back accepts SHALL be supported: one sample per cycle, giving N_SAMPLES cycles from first accept to last shift_en.

Reset
REQ-031 While n_rst=0 the controller SHALL be in state IDLE with count=0, sample_ready=0, shift_en=0, shift_data=0, frame_valid=0, overrun=0 and frame_cnt=0.
REQ-032 Assertion of n_rst mid-LOAD or mid-HOLD SHALL abort immediately to the reset values in REQ-031.
REQ-033 After n_rst is released, the first state change SHALL occur on the first rising edge with n_rst=1.

Verification
REQ-034 Full frame: en=1, sample_valid held high, sample_in=0x0..0x2F -> 48 consecutive shift_en pulses with shift_data=0x0..0x2F; frame_valid rises 1 cycle after the last pulse; the register holds 0x0..0x2F.
REQ-035 Consume: in HOLD, frame_ready=1 for 1 cycle -> frame_valid=0 and frame_cnt=1; with en=1 the next sample is accepted in the following cycle.
REQ-036 Back-pressure: frame_ready=0 for 20 cycles with sample_valid=1 -> no shift_en pulse, overrun=1; ovr_clr pulse with sample_valid=0 -> overrun=0.
REQ-037 Abort: en dropped after 10 accepts -> IDLE and count=0; a new frame of 48 samples then completes normally.
REQ-038 Reset mid-LOAD after 30 accepts -> all outputs at reset values immediately; after release, a 48-sample frame completes with frame_cnt=1 after it is consumed.
REQ-039 Gapped input: sample_valid toggled every other cycle -> 48 shift_en pulses over 95 cycles, with correct order and a single frame_valid.
